// File: rtl/operand_serializer.sv
// operand_serializer
//   Parallel-to-serial front end for the FP datapath. A vector of NUM_INPUTS
//   words (word 0 in the MSBs) is latched on accept. It is then emitted one
//   word per beat, together with the word's index, so the downstream mux/MAC
//   stage sees word k alongside select = k.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_data       packed input vector, word k = in_data[(NUM_INPUTS-k)*WIDTH-1 -: WIDTH]
//   in_valid      input handshake valid
//   in_ready      input handshake ready
//   out_data      current word
//   out_select    index of out_data within its vector
//   out_last      high on the last word of a vector
//   out_valid     output handshake valid
//   out_ready     output handshake ready
//   busy          high while a vector is held
module operand_serializer #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 2,
    localparam int SEL_W     = $clog2(NUM_INPUTS),
    localparam int IN_LENGTH = NUM_INPUTS * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_LENGTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_select,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

    state_t               state_q, state_d;
    logic [IN_LENGTH-1:0] buf_q, buf_d;
    logic [SEL_W-1:0]     idx_q, idx_d;

    logic accept;
    logic beat;
    logic idx_last;

    assign idx_last   = (idx_q == LAST_IDX);
    assign out_valid  = (state_q == STREAM);
    assign busy       = (state_q == STREAM);
    assign out_select = idx_q;
    assign out_last   = idx_last;

    // A new vector can be taken in the same cycle the last word of the
    // current one leaves, which is what keeps back-to-back vectors
    // bubble-free. Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready = rst_n & ((state_q == IDLE) |
                               ((state_q == STREAM) & idx_last & out_ready));

    assign accept = in_valid & in_ready;
    assign beat   = out_valid & out_ready;

    // Word select straight from the held buffer and index registers.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (idx_q == SEL_W'(k)) begin
                out_data = buf_q[(NUM_INPUTS-k)*WIDTH-1 -: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;

        if (beat) begin
            if (idx_last) begin
                // Index returns to 0 explicitly, so non-power-of-two
                // vector sizes never step through unused codes.
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Accept overrides the end-of-vector return to IDLE.
        if (accept) begin
            buf_d   = in_data;
            idx_d   = '0;
            state_d = STREAM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
module tb_operand_serializer;

    // Main DUT: WIDTH=32, NUM_INPUTS=4
    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_select;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    // Second DUT: WIDTH=16, NUM_INPUTS=3
    logic [47:0]  in_data3;
    logic         in_valid3;
    logic         in_ready3;
    logic [15:0]  out_data3;
    logic [1:0]   out_select3;
    logic         out_last3;
    logic         out_valid3;
    logic         out_ready3;
    logic         busy3;

    operand_serializer #(.WIDTH(32), .NUM_INPUTS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_select (out_select),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    operand_serializer #(.WIDTH(16), .NUM_INPUTS(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data3),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .out_data   (out_data3),
        .out_select (out_select3),
        .out_last   (out_last3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .busy       (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         iv;
        logic [127:0] id;
        logic         ordy;
        logic         ev;
        logic [31:0]  ed;
        logic [1:0]   es;
        logic         el;
        logic         eir;
        logic         eb;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [127:0] id, input logic ordy,
                                input logic ev, input logic [31:0] ed, input logic [1:0] es,
                                input logic el, input logic eir, input logic eb);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.es = es; v.el = el; v.eir = eir; v.eb = eb;
        return v;
    endfunction

    localparam logic [127:0] VA = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    localparam logic [127:0] VB = {32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
    localparam logic [127:0] VC = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    localparam logic [127:0] G1 = {32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};
    localparam logic [127:0] G2 = {32'hBEEF0001, 32'hBEEF0002, 32'hBEEF0003, 32'hBEEF0004};
    localparam logic [127:0] G3 = {32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
    localparam logic [127:0] G4 = {32'hF00D0001, 32'hF00D0002, 32'hF00D0003, 32'hF00D0004};

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;

        //               iv id  ordy | ev  data          sel last inr busy
        // idle, then single vector with out_ready high
        tbl.push_back(mk(0, '0, 1,   0, 32'h0,         0, 0, 1, 0));
        tbl.push_back(mk(1, VA, 1,   0, 32'h0,         0, 0, 1, 0));
        tbl.push_back(mk(0, '0, 1,   1, 32'h3F800000,  0, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h40000000,  1, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h40400000,  2, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h40800000,  3, 1, 1, 1));
        tbl.push_back(mk(0, '0, 1,   0, 32'h0,         0, 0, 1, 0));
        // backpressure; in_valid offered during the stalled last beat is not taken
        tbl.push_back(mk(1, VA, 0,   0, 32'h0,         0, 0, 1, 0));
        tbl.push_back(mk(0, '0, 1,   1, 32'h3F800000,  0, 0, 0, 1));
        tbl.push_back(mk(0, '0, 0,   1, 32'h40000000,  1, 0, 0, 1));
        tbl.push_back(mk(0, '0, 0,   1, 32'h40000000,  1, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h40000000,  1, 0, 0, 1));
        tbl.push_back(mk(0, '0, 0,   1, 32'h40400000,  2, 0, 0, 1));
        tbl.push_back(mk(0, '0, 0,   1, 32'h40400000,  2, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h40400000,  2, 0, 0, 1));
        tbl.push_back(mk(1, VB, 0,   1, 32'h40800000,  3, 1, 0, 1));
        tbl.push_back(mk(1, VB, 0,   1, 32'h40800000,  3, 1, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h40800000,  3, 1, 1, 1));
        // back-to-back A then B, B offered early but taken only on A's last beat
        tbl.push_back(mk(1, VA, 1,   0, 32'h0,         0, 0, 1, 0));
        tbl.push_back(mk(1, VB, 1,   1, 32'h3F800000,  0, 0, 0, 1));
        tbl.push_back(mk(1, VB, 1,   1, 32'h40000000,  1, 0, 0, 1));
        tbl.push_back(mk(1, VB, 1,   1, 32'h40400000,  2, 0, 0, 1));
        tbl.push_back(mk(1, VB, 1,   1, 32'h40800000,  3, 1, 1, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h41000000,  0, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h41100000,  1, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h41200000,  2, 0, 0, 1));
        tbl.push_back(mk(0, '0, 1,   1, 32'h41300000,  3, 1, 1, 1));
        // input churn while streaming C
        tbl.push_back(mk(1, VC, 1,   0, 32'h0,         0, 0, 1, 0));
        tbl.push_back(mk(1, G1, 1,   1, 32'h11111111,  0, 0, 0, 1));
        tbl.push_back(mk(1, G2, 1,   1, 32'h22222222,  1, 0, 0, 1));
        tbl.push_back(mk(1, G3, 1,   1, 32'h33333333,  2, 0, 0, 1));
        tbl.push_back(mk(0, G4, 1,   1, 32'h44444444,  3, 1, 1, 1));
        tbl.push_back(mk(0, '0, 1,   0, 32'h0,         0, 0, 1, 0));

        // Reset state while rst_n held low
        #12;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst out_select", {30'b0, out_select}, 32'd0);
        chk("rst out_last", {31'b0, out_last}, 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst3 out_valid", {31'b0, out_valid3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
            chk($sformatf("row%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].eir});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d out_data", i), out_data, tbl[i].ed);
                chk($sformatf("row%0d out_select", i), {30'b0, out_select}, {30'b0, tbl[i].es});
                chk($sformatf("row%0d out_last", i), {31'b0, out_last}, {31'b0, tbl[i].el});
            end
        end

        // Async reset in the middle of a vector
        @(negedge clk);
        in_valid = 1'b1; in_data = VA; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("pre-reset select", {30'b0, out_select}, 32'd1);
        chk("pre-reset valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", {31'b0, out_valid}, 32'd0);
        chk("async busy", {31'b0, busy}, 32'd0);
        chk("async out_select", {30'b0, out_select}, 32'd0);
        chk("async in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("post-reset%0d out_valid", c), {31'b0, out_valid}, 32'd0);
            chk($sformatf("post-reset%0d in_ready", c), {31'b0, in_ready}, 32'd1);
            @(negedge clk);
        end

        // NUM_INPUTS=3, WIDTH=16: two back-to-back vectors
        begin
            logic [15:0] exp_w [6];
            logic [1:0]  exp_s [6];
            exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'hAAAA, 16'hBBBB, 16'hCCCC};
            exp_s = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
            in_valid3 = 1'b1;
            in_data3 = {16'h1111, 16'h2222, 16'h3333};
            out_ready3 = 1'b1;
            #1;
            chk("n3 idle in_ready", {31'b0, in_ready3}, 32'd1);
            @(negedge clk);
            in_data3 = {16'hAAAA, 16'hBBBB, 16'hCCCC};
            for (int c = 0; c < 6; c++) begin
                if (c == 3) in_valid3 = 1'b0;
                #1;
                chk($sformatf("n3 beat%0d valid", c), {31'b0, out_valid3}, 32'd1);
                chk($sformatf("n3 beat%0d data", c), {16'b0, out_data3}, {16'b0, exp_w[c]});
                chk($sformatf("n3 beat%0d select", c), {30'b0, out_select3}, {30'b0, exp_s[c]});
                chk($sformatf("n3 beat%0d last", c), {31'b0, out_last3},
                    (exp_s[c] == 2'd2) ? 32'd1 : 32'd0);
                @(negedge clk);
            end
            #1;
            chk("n3 end valid", {31'b0, out_valid3}, 32'd0);
            chk("n3 end select", {30'b0, out_select3}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Select code 3 must never be driven by the 3-input instance.
    always @(negedge clk) begin
        if (rst_n && out_valid3 && out_select3 == 2'd3) begin
            errors++;
            $display("FAIL n3 select range: got %0d expected <3", out_select3);
        end
    end

endmodule
